// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, start-bit centre qualification,
// LSB-first data capture and stop-bit check with registered one-clk result pulses.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_line,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 rx_s;
    logic                 prev_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 half_tick;
    logic                 full_tick;
    logic                 bit_take;
    logic                 stop_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_line;
            rx_s  <= sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start needs a high-to-low transition between ticks, so a held-low break never restarts.
    always_comb begin
        state_next = state;
        if (sample_tick) begin
            case (state)
                IDLE:  if (!rx_s && prev_s) state_next = START;
                START: if (half_tick) state_next = rx_s ? IDLE : DATA;
                DATA:  if (full_tick && bit_cnt == BIT_LAST) state_next = STOP;
                STOP:  if (full_tick) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy   = (state != IDLE);
        half_tick = sample_tick && (tick_cnt == TICK_HALF);
        full_tick = sample_tick && (tick_cnt == TICK_LAST);
        bit_take  = (state == DATA) && full_tick;
        stop_take = (state == STOP) && full_tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_s    <= 1'b1;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (sample_tick) begin
            prev_s <= rx_s;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START: begin
                    if (half_tick) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_take) begin
                        tick_cnt  <= '0;
                        bit_cnt   <= bit_cnt + BW'(1);
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (stop_take) begin
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= stop_take && rx_s;
            frame_err <= stop_take && !rx_s;
            if (stop_take && rx_s) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule
